mano_mem_responder: RTL

- Main-memory responder on the cache-to-memory interface, sitting below the direct-mapped cache.
- Accepts single-word read and write requests from the cache miss/write-back path.
- Services each request after a programmable latency and signals completion with a one-cycle acknowledge.
- Holds the MANO 4096x16 word store and keeps saturating read/write activity counters for performance measurement.

---
 rtl/mano_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mano_mem_responder.sv
// MANO main-memory responder below the direct-mapped cache: single-word reads and
// writes serviced after a programmable latency, one-cycle ack, saturating counters.
module mano_mem_responder #(
    parameter int    ADDR_W    = 12,
    parameter int    DATA_W    = 16,
    parameter int    DEPTH     = 4096,
    parameter int    RD_LAT    = 3,
    parameter int    WR_LAT    = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [ADDR_W:0]  C_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] C_WR_LOAD = CNT_W'(WR_LAT - 1);
    localparam logic [15:0]      C_SAT     = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_isWr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdData;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;
    logic [15:0]       r_rdCount;
    logic [15:0]       r_wrCount;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_inRange;
    logic [IDX_W-1:0]  w_idx;
    logic              w_done;
    logic              w_memWe;

    assign w_inRange = ({1'b0, r_addr} < C_DEPTH);
    assign w_idx     = r_addr[IDX_W-1:0];
    assign w_done    = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_memWe   = w_done && r_isWr && w_inRange;

    // The array has no reset; an aborted request never reaches w_done, so reset cannot corrupt it.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_isWr    <= 1'b0;
            r_cnt     <= '0;
            r_rdData  <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_rdCount <= '0;
            r_wrCount <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A simultaneous read is dropped in favour of the write.
                    if (mem_wr || mem_rd) begin
                        r_addr  <= mem_addr;
                        r_wdata <= wr_data;
                        r_isWr  <= mem_wr;
                        r_cnt   <= mem_wr ? C_WR_LOAD : C_RD_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_ack   <= 1'b1;
                        r_err   <= ~w_inRange;
                        r_state <= S_ACK;
                        if (r_isWr) begin
                            if (r_wrCount != C_SAT) begin
                                r_wrCount <= r_wrCount + 16'd1;
                            end
                        end else begin
                            r_rdData <= w_inRange ? r_mem[w_idx] : '0;
                            if (r_rdCount != C_SAT) begin
                                r_rdCount <= r_rdCount + 16'd1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_data  = r_rdData;
    assign mem_ack  = r_ack;
    assign mem_err  = r_err;
    assign busy     = r_busy;
    assign rd_count = r_rdCount;
    assign wr_count = r_wrCount;

endmodule
